rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
Shares one synchronous ROM read port between NREQ requesters. The ROM has a 2-cycle read latency and an `ena`-gated first stage.
- Round-robin arbitration of read requests.
- Drives the ROM address and enable from registers.
- Tracks in-flight reads with a tag pipeline and returns each word to its owner.
- Built-in full-ROM scan: reads every address and produces an XOR checksum for integrity checking of LUT contents.

Parameters:
- NREQ, 4, number of requesters (2..8)
- MXADRB, 9, ROM address width
- MXDATB, 11, ROM data width
- ROMLENGTH, 1<<MXADRB, number of ROM words scanned

Ports:
- clka  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester read request
- req_addr  in  NREQ*MXADRB  packed addresses; requester i at [i*MXADRB +: MXADRB]
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i]
- rsp_valid  out  NREQ  one-hot; read data valid for requester i
- rsp_data  out  MXDATB  read data, shared by all requesters
- scan_start  in  1  pulse; starts a full-ROM scan
- scan_busy  out  1  scan in progress
- scan_done  out  1  one-cycle pulse; checksum valid
- scan_checksum  out  MXDATB  XOR of all ROM words
- rom_ena  out  1  to ROM ena
- rom_addra  out  MXADRB  to ROM addra
- rom_douta  in  MXDATB  from ROM douta

Behaviour:
- Reset (async, rst_n=0) values:
  - req_ready, rsp_valid, rom_ena, rom_addra, scan_busy, scan_done, scan_checksum = 0.
  - Tag pipeline cleared.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - FSM = IDLE.
- Arbitration (FSM IDLE only):
  - req_ready is combinational from req_valid and the pointer.
  - Search starts at pointer+1, wrapping modulo NREQ; at most one grant per cycle.
  - Pointer updates to the granted index on a transfer.
  - Requesters hold valid and addr stable until ready.
  - req_ready = 0 in all other states.
- Issue stage: on a transfer in cycle T, rom_ena=1 and rom_addra=addr are registered and visible in cycle T+1; otherwise rom_ena=0 and rom_addra holds.
- Latency:
  - ROM rd_data0 is loaded at the end of T+1; douta is visible in T+3.
  - rsp_valid[i] = 1 in cycle T+3, with rsp_data = rom_douta (combinational pass-through).
  - Fixed 3-cycle latency. Throughput 1 read/cycle. No response backpressure.
- Tag pipeline: 3 stages, each a one-hot NREQ field plus a scan bit, advancing every cycle unconditionally.
- FSM states:
  - IDLE: on scan_start, go to SCAN. Clear scan_checksum, clear the address counter, set scan_busy=1.
  - SCAN: issue address counter 0..ROMLENGTH-1, one per cycle, with the scan tag set. After issuing ROMLENGTH-1, go to DRAIN.
  - DRAIN: wait until no scan tag remains in the pipeline, then go to DONE.
  - DONE: scan_done=1 for one cycle, scan_busy=0, then go to IDLE.
- Checksum: scan_checksum ^= rom_douta whenever stage-3 scan tag = 1; it holds until the next scan_start.
- scan_start is ignored outside IDLE.
- A scan starting while requester reads are in flight lets those reads complete normally (tags are distinct).
- Counter wraps never occur: the counter width is MXADRB+1, with terminal compare at ROMLENGTH-1.
- Reset mid-operation drops all in-flight reads and any scan; no rsp_valid occurs after rst_n release until a new transfer.

Optional Feature:
ROM_ARB_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; RR pointer removed.
- Undefined: round-robin as above.
- Latency and scan behaviour are identical in both cases.

Decomposition:
- Package rom_arb_pkg holds:
  - FSM state enum (IDLE, SCAN, DRAIN, DONE).
  - ROM_RD_LAT=2.
  - ARB_RSP_LAT=3.
- One sub-module, rr_arbiter (NREQ):
  - Inputs: req vector, advance strobe.
  - Outputs: one-hot grant.
  - Contents: pointer register, and the ROM_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Single read: req0 addr 0x005 in cycle 0 → req_ready=0001 in cycle 0; rom_ena=1 and rom_addra=0x005 in cycle 1; rsp_valid=0001 and rsp_data=mem[5] in cycle 3.
- All 4 requesters valid continuously → grant order 0,1,2,3,0,1…; each requester gets 1 response per 4 cycles, with data matching its address.
- Requester 2 issues distinct addresses every cycle for 20 cycles → 20 consecutive rsp_valid=0100 cycles, in order, 3-cycle latency.
- MXADRB=4, ROM file of known content, scan_start in cycle 0 → scan_busy in cycles 1..19; scan_done pulse in cycle 20; scan_checksum = XOR of the 16 words.
- scan_start while req1 is valid and one read is in flight → in-flight response delivered, req_ready=0 during scan, req1 granted in the cycle after DONE.
- rst_n low for 1 cycle with 3 reads in flight → all outputs are 0 immediately; no rsp_valid in the 5 cycles after release.
- (ROM_ARB_FIXED_PRIO_EN) req0 and req3 valid continuously → req3 never granted.

Source files
------------

// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read-port arbiter.
//   arb_state_t  : control FSM states (IDLE, SCAN, DRAIN, DONE)
//   ROM_RD_LAT   : read latency of the attached synchronous ROM (addr -> douta)
//   ARB_RSP_LAT  : request transfer -> rsp_valid latency seen by a requester
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int ROM_RD_LAT  = 2;
    localparam int ARB_RSP_LAT = 3;

endpackage

// File: rtl/rom_read_arbiter_rr_arbiter.sv
// Request arbiter for the shared ROM read port.
// Default build: round-robin, the search starts one past the last winner.
// With ROM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and no pointer register exists.
// Ports:
//   clka, rst_n : clock, asynchronous active-low reset
//   req         : per-requester request (already qualified by the caller)
//   adv         : a transfer happened this cycle; move the pointer to the winner
//   grant       : one-hot grant, combinational from req (and the pointer)
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clka,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            adv,
    output logic [NREQ-1:0] grant
);

`ifdef ROM_ARB_FIXED_PRIO_EN

    logic unused_fp;
    assign unused_fp = ^{clka, rst_n, adv};

    // Walk from the top down so the lowest requesting index is the last write.
    always_comb begin
        grant = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

`else

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand_idx;
    int               cand;
    logic             found;

    // Candidate order is ptr+1, ptr+2, ... wrapping, so the previous winner
    // is considered last.
    always_comb begin
        grant    = '0;
        gnt_idx  = ptr;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = PTR_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                gnt_idx         = cand_idx;
            end
        end
    end

    // Reset value NREQ-1 makes requester 0 the first candidate.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= PTR_W'(NREQ - 1);
        end else if (adv) begin
            ptr <= gnt_idx;
        end
    end

`endif

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one synchronous ROM read port (2-cycle latency, ena-gated first
// stage) between NREQ requesters, and provides a built-in full-ROM scan that
// XORs every word into a checksum.
// Optional build macro: ROM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin arbitration.
// Ports:
//   clka, rst_n     : clock, asynchronous active-low reset
//   req_valid       : per-requester read request (held until req_ready)
//   req_addr        : packed addresses, requester i at [i*MXADRB +: MXADRB]
//   req_ready       : one-hot grant (combinational), only in IDLE
//   rsp_valid       : one-hot, read data for requester i valid this cycle
//   rsp_data        : read data shared by all requesters (douta pass-through)
//   scan_start      : pulse, starts a full-ROM scan (ignored unless IDLE)
//   scan_busy       : scan in progress
//   scan_done       : one-cycle pulse, scan_checksum is final
//   scan_checksum   : XOR of all ROM words read by the last scan
//   rom_ena         : ROM ena (registered)
//   rom_addra       : ROM addra (registered, holds when idle)
//   rom_douta       : ROM douta
// Timing: transfer in cycle T -> rom_ena/rom_addra in T+1 -> rsp_valid in T+3.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int MXADRB    = 9,
    parameter int MXDATB    = 11,
    parameter int ROMLENGTH = 1 << MXADRB
) (
    input  logic                   clka,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*MXADRB-1:0] req_addr,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [MXDATB-1:0]      rsp_data,
    input  logic                   scan_start,
    output logic                   scan_busy,
    output logic                   scan_done,
    output logic [MXDATB-1:0]      scan_checksum,
    output logic                   rom_ena,
    output logic [MXADRB-1:0]      rom_addra,
    input  logic [MXDATB-1:0]      rom_douta
);

    // One extra bit so the counter can step past the last address without wrapping.
    localparam logic [MXADRB:0] CNT_LAST = (MXADRB + 1)'(ROMLENGTH - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [MXADRB:0]   scan_cnt;
    logic              arb_en;
    logic              scan_go;
    logic              scan_issue;
    logic              xfer;
    logic [NREQ-1:0]   xfer_vec;
    logic [MXADRB-1:0] gnt_addr;

    logic [NREQ-1:0]   tag_p0;
    logic [NREQ-1:0]   tag_p1;
    logic [NREQ-1:0]   tag_p2;
    logic              scan_p0;
    logic              scan_p1;
    logic              scan_p2;

    // A scan_start in IDLE takes the port: no grant is issued that cycle, so
    // any waiting requester is served after the scan.
    assign scan_go    = (state == IDLE) && scan_start;
    assign arb_en     = (state == IDLE) && !scan_start;
    assign scan_issue = (state == SCAN);
    assign xfer_vec   = req_valid & req_ready;
    assign xfer       = |xfer_vec;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clka  (clka),
        .rst_n (rst_n),
        .req   (req_valid & {NREQ{arb_en}}),
        .adv   (xfer),
        .grant (req_ready)
    );

    always_comb begin
        gnt_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                gnt_addr = req_addr[i*MXADRB +: MXADRB];
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DRAIN leaves once only the stage-3 slot can still hold a scan read:
    // that last word is absorbed this cycle, so DONE sees the final checksum.
    always_comb begin
        state_nxt = state;
        scan_busy = 1'b0;
        scan_done = 1'b0;
        case (state)
            IDLE: begin
                if (scan_start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                scan_busy = 1'b1;
                if (scan_cnt == CNT_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                scan_busy = 1'b1;
                if (!(scan_p0 || scan_p1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                scan_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (scan_go) begin
            scan_cnt <= '0;
        end else if (scan_issue) begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // ---- stage p0: issue to ROM (ena/addr registered, tag follows) ----
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            rom_ena   <= 1'b0;
            rom_addra <= '0;
            tag_p0    <= '0;
            scan_p0   <= 1'b0;
        end else begin
            rom_ena <= xfer || scan_issue;
            tag_p0  <= xfer_vec;
            scan_p0 <= scan_issue;
            if (xfer) begin
                rom_addra <= gnt_addr;
            end else if (scan_issue) begin
                rom_addra <= scan_cnt[MXADRB-1:0];
            end
        end
    end

    // ---- stage p1: ROM first read stage loads ----
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            tag_p1  <= '0;
            scan_p1 <= 1'b0;
        end else begin
            tag_p1  <= tag_p0;
            scan_p1 <= scan_p0;
        end
    end

    // ---- stage p2: ROM douta valid, tag aligned with it ----
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            tag_p2  <= '0;
            scan_p2 <= 1'b0;
        end else begin
            tag_p2  <= tag_p1;
            scan_p2 <= scan_p1;
        end
    end

    assign rsp_valid = tag_p2;
    assign rsp_data  = rom_douta;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            scan_checksum <= '0;
        end else if (scan_go) begin
            scan_checksum <= '0;
        end else if (scan_p2) begin
            scan_checksum <= scan_checksum ^ rom_douta;
        end
    end

endmodule

// File: tb/tb_rom_read_arbiter.sv
module tb_rom_read_arbiter;
    import rom_arb_pkg::*;

    localparam int NREQ   = 4;
    localparam int MXADRB = 4;
    localparam int MXDATB = 11;
    localparam int L      = 1 << MXADRB;
    localparam int MAXC   = 1024;

    logic        clka = 1'b0;
    always #5 clka = ~clka;

    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  a [4];
    logic [15:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [10:0] rsp_data;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [10:0] scan_checksum;
    logic        rom_ena;
    logic [3:0]  rom_addra;
    logic [10:0] rom_douta;

    assign req_addr = {a[3], a[2], a[1], a[0]};

    rom_read_arbiter #(
        .NREQ      (NREQ),
        .MXADRB    (MXADRB),
        .MXDATB    (MXDATB),
        .ROMLENGTH (L)
    ) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .scan_start    (scan_start),
        .scan_busy     (scan_busy),
        .scan_done     (scan_done),
        .scan_checksum (scan_checksum),
        .rom_ena       (rom_ena),
        .rom_addra     (rom_addra),
        .rom_douta     (rom_douta)
    );

    // ROM: mem[i] = i*73 + 19, ena-gated first stage then output register.
    logic [10:0] mem [L];
    logic [10:0] rom_pipe [ROM_RD_LAT];
    initial for (int i = 0; i < L; i++) mem[i] = 11'(i * 73 + 19);
    always @(posedge clka) begin
        if (rom_ena) rom_pipe[0] <= mem[rom_addra];
        for (int i = 1; i < ROM_RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_douta = rom_pipe[ROM_RD_LAT-1];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clka) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // ---------------- behavioural model ----------------
    function automatic logic [3:0] pick(logic [3:0] v, int p);
        logic [3:0] r = '0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) if (v[i]) r = 4'(1 << i);
`else
        for (int k = NREQ; k >= 1; k--) if (v[(p + k) % NREQ]) r = 4'(1 << ((p + k) % NREQ));
`endif
        return r;
    endfunction

    function automatic logic [10:0] xor_first(int k);
        logic [10:0] r = '0;
        for (int i = 0; i < k; i++) r = r ^ mem[i];
        return r;
    endfunction

    logic [3:0]  sch_rv [MAXC];
    logic [10:0] sch_rd [MAXC];
    int          m_ptr  = NREQ - 1;
    int          scan_s = -1;
    logic        m_ena  = 1'b0;
    logic [3:0]  m_addr = '0;
    int          mc, mg, mk, mj;
    logic [3:0]  e_rdy, e_rv;
    logic [10:0] e_ck;
    logic        e_busy, e_done, m_act, m_start;

    initial for (int i = 0; i < MAXC; i++) sch_rv[i] = '0;

    always @(negedge clka) begin
        mc = cyc;
        if (mc < MAXC - 8) begin
            if (!rst_n) begin
                chk("m_rst_ready", 32'(req_ready), 32'(0));
                chk("m_rst_rsp_valid", 32'(rsp_valid), 32'(0));
                chk("m_rst_rom_ena", 32'(rom_ena), 32'(0));
                chk("m_rst_rom_addra", 32'(rom_addra), 32'(0));
                chk("m_rst_busy", 32'(scan_busy), 32'(0));
                chk("m_rst_done", 32'(scan_done), 32'(0));
                chk("m_rst_checksum", 32'(scan_checksum), 32'(0));
                for (int i = 0; i <= ARB_RSP_LAT + 1; i++) sch_rv[mc + i] = '0;
                m_ptr  = NREQ - 1;
                scan_s = -1;
                m_ena  = 1'b0;
                m_addr = '0;
            end else begin
                m_act   = (scan_s >= 0) && (mc > scan_s) && (mc <= scan_s + L + ARB_RSP_LAT + 1);
                e_busy  = (scan_s >= 0) && (mc > scan_s) && (mc <= scan_s + L + ARB_RSP_LAT);
                e_done  = (scan_s >= 0) && (mc == scan_s + L + ARB_RSP_LAT + 1);
                m_start = !m_act && scan_start;
                e_rdy   = (m_act || m_start) ? 4'b0 : pick(req_valid, m_ptr);
                mk      = (scan_s < 0) ? 0 : mc - scan_s - 1 - ARB_RSP_LAT;
                if (mk < 0) mk = 0;
                if (mk > L) mk = L;
                e_ck    = xor_first(mk);
                e_rv    = sch_rv[mc];
                chk("m_req_ready", 32'(req_ready), 32'(e_rdy));
                chk("m_rom_ena", 32'(rom_ena), 32'(m_ena));
                chk("m_rom_addra", 32'(rom_addra), 32'(m_addr));
                chk("m_rsp_valid", 32'(rsp_valid), 32'(e_rv));
                if (e_rv != 0) chk("m_rsp_data", 32'(rsp_data), 32'(sch_rd[mc]));
                chk("m_scan_busy", 32'(scan_busy), 32'(e_busy));
                chk("m_scan_done", 32'(scan_done), 32'(e_done));
                chk("m_scan_checksum", 32'(scan_checksum), 32'(e_ck));
                mj = mc - scan_s - 1;
                if (e_rdy != 0) begin
                    mg = 0;
                    for (int i = 0; i < NREQ; i++) if (e_rdy[i]) mg = i;
                    m_ptr  = mg;
                    m_ena  = 1'b1;
                    m_addr = a[mg];
                    sch_rv[mc + ARB_RSP_LAT] = e_rdy;
                    sch_rd[mc + ARB_RSP_LAT] = mem[a[mg]];
                end else if (m_act && mj >= 0 && mj < L) begin
                    m_ena  = 1'b1;
                    m_addr = 4'(mj);
                end else begin
                    m_ena = 1'b0;
                end
                if (m_start) scan_s = mc;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic neg();
        @(negedge clka);
    endtask

`ifdef ROM_ARB_FIXED_PRIO_EN
    logic [3:0] exp_order [4] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    logic [3:0] exp_order [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

    int rc, s, gc, dc, g0, g3;

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        scan_start = 1'b0;
        for (int i = 0; i < 4; i++) a[i] = '0;

        // reset state
        neg();
        neg();
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rom_ena", 32'(rom_ena), 32'(0));
        chk("rst_checksum", 32'(scan_checksum), 32'(0));
        tick();
        rst_n = 1'b1;
        neg(); tick();
        neg(); tick();

        // single read, requester 0, address 5
        req_valid = 4'b0001; a[0] = 4'h5;
        neg(); chk("single_ready", 32'(req_ready), 32'h1); tick();
        req_valid = 4'b0000;
        neg(); chk("single_rom_ena", 32'(rom_ena), 32'h1);
        chk("single_rom_addra", 32'(rom_addra), 32'h5); tick();
        neg(); tick();
        neg(); chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_data", 32'(rsp_data), 32'h180); tick();

        // all four requesting continuously
        req_valid = 4'hF; a[0] = 4'd8; a[1] = 4'd9; a[2] = 4'd10; a[3] = 4'd11;
        for (int k = 0; k < 12; k++) begin
            neg();
            if (k < 4) chk("grant_order", 32'(req_ready), 32'(exp_order[k]));
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin neg(); tick(); end

        // requester 2 streams 20 addresses back to back
        rc = 0;
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin req_valid = 4'b0100; a[2] = 4'(k); end
            else req_valid = '0;
            neg();
            if (rsp_valid == 4'b0100) rc++;
            tick();
        end
        chk("req2_stream_rsp_count", 32'(rc), 32'd20);

        // scan with a read in flight and requester 1 waiting
        req_valid = 4'b0001; a[0] = 4'd3;
        neg(); chk("pre_scan_grant", 32'(req_ready), 32'h1); tick();
        req_valid = 4'b0010; a[1] = 4'd7; scan_start = 1'b1; s = cyc;
        neg(); chk("scan_start_no_grant", 32'(req_ready), 32'h0); tick();
        scan_start = 1'b0;
        neg(); chk("scan_busy_first", 32'(scan_busy), 32'h1); tick();
        neg(); chk("inflight_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("inflight_rsp_data", 32'(rsp_data), 32'h0EE); tick();
        scan_start = 1'b1;
        neg(); chk("scan_ready_low", 32'(req_ready), 32'h0); tick();
        scan_start = 1'b0;
        gc = -1; dc = -1;
        for (int n = 0; n < 40; n++) begin
            neg();
            if (scan_done) begin
                dc = cyc;
                chk("scan_checksum_final", 32'(scan_checksum), 32'h2B0);
            end
            if (req_ready[1]) begin gc = cyc; break; end
            tick();
        end
        chk("scan_done_cycle", 32'(dc - s), 32'd20);
        chk("req1_grant_cycle", 32'(gc - s), 32'd21);
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin neg(); tick(); end
        neg(); chk("checksum_hold", 32'(scan_checksum), 32'h2B0); tick();

        // reset with three reads in flight
        req_valid = 4'b1000; a[3] = 4'd1;
        neg(); tick();
        a[3] = 4'd2;
        neg(); tick();
        a[3] = 4'd4;
        neg(); tick();
        req_valid = '0; rst_n = 1'b0;
        neg(); chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("midrst_rom_ena", 32'(rom_ena), 32'h0);
        chk("midrst_checksum", 32'(scan_checksum), 32'h0); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            neg(); chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0); tick();
        end

        // requesters 0 and 3 both continuously
        req_valid = 4'b1001; a[0] = 4'd2; a[3] = 4'd9; g0 = 0; g3 = 0;
        for (int k = 0; k < 8; k++) begin
            neg();
            if (req_ready[3]) g3++;
            if (req_ready[0]) g0++;
            tick();
        end
        req_valid = '0;
`ifdef ROM_ARB_FIXED_PRIO_EN
        chk("fixed_req3_grants", 32'(g3), 32'd0);
        chk("fixed_req0_grants", 32'(g0), 32'd8);
`else
        chk("rr_req3_grants", 32'(g3), 32'd4);
        chk("rr_req0_grants", 32'(g0), 32'd4);
`endif
        for (int k = 0; k < 5; k++) begin neg(); tick(); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
        $fatal(1, "watchdog");
    end

endmodule
